// File: rtl/axis_spi_pkg.sv
// rtl/axis_spi_pkg.sv - shared SPI bridge types and constants.
package axis_spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - multi-flop synchroniser for one async pin with edge detect.
module spi_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic sresetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              delayed;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      chain   <= {STAGES{RESET_VAL}};
      delayed <= RESET_VAL;
    end else begin
      chain   <= {chain[STAGES-2:0], din};
      delayed <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~delayed;
  assign fall  = ~level & delayed;

endmodule

// File: rtl/axis_spi_slave_bridge.sv
// rtl/axis_spi_slave_bridge.sv - SPI mode-0 slave bridging to AXI-Stream rx/tx ports.
// Define AXIS_SPI_SLAVE_ERR_FLAGS_EN to add sticky overflow/underrun flags with err_clr.
module axis_spi_slave_bridge
  import axis_spi_pkg::*;
#(
  parameter int AXIS_BYTES  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    sresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  output logic                    axis_o_tuser,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
  ,
  input  logic                    err_clr,
  output logic                    overflow,
  output logic                    underrun
`endif
);

  localparam int N  = AXIS_BYTES * 8;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_deassert, cs_assert;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .sresetn(sresetn), .din(sck),
    .level(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  // Idles high so miso_oe is low straight out of reset.
  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .sresetn(sresetn), .din(cs_n),
    .level(cs_s), .rise(cs_deassert), .fall(cs_assert)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .sresetn(sresetn), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t    state, state_next;
  logic [N-1:0]  tx_sreg;
  logic [N-2:0]  rx_sreg;
  logic [CW-1:0] ctr;
  logic          word_done, first_word, load;

  logic sample_edge, shift_edge, active, rx_edge, tx_edge;
  logic word_last, word_cplt, o_accept;
  logic [N-1:0] rx_word;

  assign sample_edge = SPI_MODE0[0] ? sck_fall : sck_rise;
  assign shift_edge  = SPI_MODE0[0] ? sck_rise : sck_fall;
  // A cs_n rise in the same cycle as an sck edge suppresses the edge.
  assign active    = (state == ACTIVE) && !cs_deassert;
  assign rx_edge   = active && sample_edge;
  assign tx_edge   = active && shift_edge;
  assign word_last = (ctr == LAST);
  assign word_cplt = rx_edge && word_last;
  assign o_accept  = !axis_o_tvalid || axis_o_tready;
  assign rx_word   = {rx_sreg, mosi_s};

  always_ff @(posedge clk) begin
    if (!sresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_assert) begin
          state_next = ACTIVE;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_deassert)                state_next = IDLE;
        else if (tx_edge && word_done) load       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign axis_i_tready = load & axis_i_tvalid;
  assign miso          = tx_sreg[N-1];
  assign miso_oe       = ~cs_s;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      tx_sreg       <= '0;
      rx_sreg       <= '0;
      ctr           <= '0;
      word_done     <= 1'b0;
      first_word    <= 1'b0;
      axis_o_tvalid <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tuser  <= 1'b0;
    end else begin
      if (load)         tx_sreg <= axis_i_tvalid ? axis_i_tdata : '0;
      else if (tx_edge) tx_sreg <= {tx_sreg[N-2:0], 1'b0};

      if (cs_deassert) begin
        ctr       <= '0;
        word_done <= 1'b0;
      end else if (rx_edge) begin
        rx_sreg   <= rx_word[N-2:0];
        ctr       <= word_last ? '0 : ctr + CW'(1);
        word_done <= word_last;
      end else if (tx_edge) begin
        word_done <= 1'b0;
      end

      if (cs_assert)                    first_word <= 1'b1;
      else if (word_cplt && o_accept)   first_word <= 1'b0;

      // Overflow keeps the held word; the new one is dropped.
      if (word_cplt && o_accept) begin
        axis_o_tdata  <= rx_word;
        axis_o_tvalid <= 1'b1;
        axis_o_tuser  <= first_word;
      end else if (axis_o_tready) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (word_cplt && !o_accept) overflow <= 1'b1;
      else if (err_clr)           overflow <= 1'b0;
      if (load && !axis_i_tvalid) underrun <= 1'b1;
      else if (err_clr)           underrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axis_spi_slave_bridge.sv
// tb/tb_axis_spi_slave_bridge.sv - self-checking bench for axis_spi_slave_bridge.
module tb_axis_spi_slave_bridge;

  logic       clk = 1'b0;
  logic       sresetn;
  logic       axis_i_tready;
  logic       axis_i_tvalid = 1'b0;
  logic [7:0] axis_i_tdata  = 8'h00;
  logic       axis_o_tready;
  logic       axis_o_tvalid;
  logic [7:0] axis_o_tdata;
  logic       axis_o_tuser;
  logic       sck, cs_n, mosi, miso, miso_oe;
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
  logic       err_clr, overflow, underrun;
`endif

  axis_spi_slave_bridge #(.AXIS_BYTES(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid), .axis_i_tdata(axis_i_tdata),
    .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid), .axis_o_tdata(axis_o_tdata),
    .axis_o_tuser(axis_o_tuser),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
    , .err_clr(err_clr), .overflow(overflow), .underrun(underrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_q[$];
  int         pops = 0;
  logic       hs = 1'b0;
  logic [7:0] rx_q[$];
  logic       rxu_q[$];
  logic [7:0] miso_q[$];

  // tx source: presents the queue head; a handshake seen mid-cycle pops it next cycle
  initial begin
    forever begin
      @(negedge clk);
      if (hs) begin
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        pops++;
      end
      axis_i_tvalid = (tx_q.size() > 0);
      axis_i_tdata  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      #1 hs = axis_i_tvalid && axis_i_tready;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (axis_o_tvalid && axis_o_tready) begin
        rx_q.push_back(axis_o_tdata);
        rxu_q.push_back(axis_o_tuser);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic spi_start();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_word(input logic [7:0] w, input int nbits);
    logic [7:0] got;
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = w[i];
      repeat (5) @(negedge clk);
      got[i] = miso;
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    if (nbits == 8) miso_q.push_back(got);
  endtask

  task automatic spi_end();
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({axis_i_tready, axis_o_tvalid, axis_o_tdata, axis_o_tuser, miso, miso_oe} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {axis_i_tready, axis_o_tvalid, axis_o_tdata, axis_o_tuser, miso, miso_oe});
    end
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
    checks++;
    if ({overflow, underrun} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00", {overflow, underrun});
    end
`endif
    sresetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int pb, rb;
    tx_q.push_back(8'hA5);
    @(negedge clk);
    pb = pops; rb = rx_q.size(); miso_q.delete();
    spi_start(); spi_word(8'h3C, 8); spi_end();
    checks++;
    if (miso_q.size() != 1 || miso_q[0] !== 8'hA5) begin
      failures++;
      $display("FAIL single_miso got=%h n=%0d exp=a5", miso_q.size() > 0 ? miso_q[0] : 8'h00, miso_q.size());
    end
    checks++;
    if (rx_q.size() - rb != 1 || rx_q[rb] !== 8'h3C || rxu_q[rb] !== 1'b1) begin
      failures++;
      $display("FAIL single_rx n=%0d exp n=1 data=3c tuser=1", rx_q.size() - rb);
    end
    checks++;
    if (pops - pb != 1) begin
      failures++;
      $display("FAIL single_tready got=%0d exp=1", pops - pb);
    end
    tx_q.delete();
  endtask

  task automatic test_two_words();
    int pb, rb;
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    @(negedge clk);
    pb = pops; rb = rx_q.size(); miso_q.delete();
    spi_start(); spi_word(8'h81, 8); spi_word(8'h7E, 8); spi_end();
    checks++;
    if (miso_q.size() != 2 || miso_q[0] !== 8'h11 || miso_q[1] !== 8'h22) begin
      failures++;
      $display("FAIL two_miso n=%0d exp 11,22", miso_q.size());
    end
    checks++;
    if (rx_q.size() - rb != 2 || rx_q[rb] !== 8'h81 || rx_q[rb+1] !== 8'h7E ||
        rxu_q[rb] !== 1'b1 || rxu_q[rb+1] !== 1'b0) begin
      failures++;
      $display("FAIL two_rx n=%0d exp 81/1,7e/0", rx_q.size() - rb);
    end
    checks++;
    if (pops - pb != 2) begin
      failures++;
      $display("FAIL two_tready got=%0d exp=2", pops - pb);
    end
    tx_q.delete();
  endtask

  task automatic test_underrun();
    int rb;
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_cleared got=%b exp=0", underrun);
    end
`endif
    rb = rx_q.size(); miso_q.delete();
    spi_start(); spi_word(8'h96, 8); spi_end();
    checks++;
    if (miso_q.size() != 1 || miso_q[0] !== 8'h00) begin
      failures++;
      $display("FAIL underrun_miso got=%h exp=00", miso_q.size() > 0 ? miso_q[0] : 8'hFF);
    end
    checks++;
    if (rx_q.size() - rb != 1 || rx_q[rb] !== 8'h96) begin
      failures++;
      $display("FAIL underrun_rx n=%0d exp=96", rx_q.size() - rb);
    end
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_flag got=%b exp=1", underrun);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_clr got=%b exp=0", underrun);
    end
`endif
  endtask

  task automatic test_overflow();
    int rb;
    rb = rx_q.size();
    axis_o_tready = 1'b0;
    spi_start(); spi_word(8'h01, 8); spi_word(8'h02, 8); spi_end();
    checks++;
    if (axis_o_tvalid !== 1'b1 || axis_o_tdata !== 8'h01 || axis_o_tuser !== 1'b1) begin
      failures++;
      $display("FAIL overflow_hold got=%b/%h/%b exp=1/01/1", axis_o_tvalid, axis_o_tdata, axis_o_tuser);
    end
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_flag got=%b exp=1", overflow);
    end
`endif
    axis_o_tready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() - rb != 1 || rx_q[rb] !== 8'h01 || axis_o_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL overflow_drain n=%0d tvalid=%b exp n=1 data=01 tvalid=0", rx_q.size() - rb, axis_o_tvalid);
    end
  endtask

  task automatic test_abort();
    int rb;
    rb = rx_q.size();
    spi_start(); spi_word(8'hFF, 5); spi_end();
    checks++;
    if (rx_q.size() - rb != 0) begin
      failures++;
      $display("FAIL abort_partial got n=%0d exp=0", rx_q.size() - rb);
    end
    spi_start(); spi_word(8'hF0, 8); spi_end();
    checks++;
    if (rx_q.size() - rb != 1 || rx_q[rb] !== 8'hF0 || rxu_q[rb] !== 1'b1) begin
      failures++;
      $display("FAIL abort_next n=%0d exp n=1 data=f0 tuser=1", rx_q.size() - rb);
    end
  endtask

  task automatic test_reset_mid();
    int rb;
    tx_q.push_back(8'hC3); tx_q.push_back(8'h3C);
    axis_o_tready = 1'b0;
    spi_start(); spi_word(8'h55, 8); spi_word(8'hAA, 4);
    sresetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({axis_i_tready, axis_o_tvalid, axis_o_tdata, axis_o_tuser, miso, miso_oe} !== 13'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=0", {axis_i_tready, axis_o_tvalid, axis_o_tdata, axis_o_tuser, miso, miso_oe});
    end
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; axis_o_tready = 1'b1;
    repeat (3) @(negedge clk);
    sresetn = 1'b1;
    tx_q.delete();
    repeat (5) @(negedge clk);
    tx_q.push_back(8'h5A);
    @(negedge clk);
    rb = rx_q.size(); miso_q.delete();
    spi_start(); spi_word(8'hE7, 8); spi_end();
    checks++;
    if (rx_q.size() - rb != 1 || rx_q[rb] !== 8'hE7 || rxu_q[rb] !== 1'b1 ||
        miso_q.size() != 1 || miso_q[0] !== 8'h5A) begin
      failures++;
      $display("FAIL midreset_next rx_n=%0d miso_n=%0d exp rx e7/1 miso 5a", rx_q.size() - rb, miso_q.size());
    end
    tx_q.delete();
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int k, qlen, pb, rb, exp_pops;
      logic [7:0] txw[4];
      logic [7:0] mw[3];
      logic [7:0] exp_miso;
      k    = $urandom_range(1, 3);
      qlen = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) txw[i] = 8'($urandom);
      for (int i = 0; i < 3; i++) mw[i] = 8'($urandom);
      for (int i = 0; i < qlen; i++) tx_q.push_back(txw[i]);
      @(negedge clk);
      pb = pops; rb = rx_q.size(); miso_q.delete();
      spi_start();
      for (int i = 0; i < k; i++) spi_word(mw[i], 8);
      spi_end();
      // one load at cs_n fall plus one after every completed word
      exp_pops = (qlen < k + 1) ? qlen : k + 1;
      checks++;
      if (pops - pb != exp_pops) begin
        failures++;
        $display("FAIL rand_tready frame=%0d got=%0d exp=%0d", f, pops - pb, exp_pops);
      end
      checks++;
      if (rx_q.size() - rb != k || miso_q.size() != k) begin
        failures++;
        $display("FAIL rand_count frame=%0d rx=%0d miso=%0d exp=%0d", f, rx_q.size() - rb, miso_q.size(), k);
      end else begin
        for (int i = 0; i < k; i++) begin
          exp_miso = (i < qlen) ? txw[i] : 8'h00;
          checks++;
          if (miso_q[i] !== exp_miso) begin
            failures++;
            $display("FAIL rand_miso frame=%0d word=%0d got=%h exp=%h", f, i, miso_q[i], exp_miso);
          end
          checks++;
          if (rx_q[rb+i] !== mw[i] || rxu_q[rb+i] !== (i == 0)) begin
            failures++;
            $display("FAIL rand_rx frame=%0d word=%0d got=%h/%b exp=%h/%b", f, i, rx_q[rb+i], rxu_q[rb+i], mw[i], i == 0);
          end
        end
      end
      tx_q.delete();
    end
  endtask

  initial begin
    sresetn = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; axis_o_tready = 1'b1;
`ifdef AXIS_SPI_SLAVE_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_two_words();
    test_underrun();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
